// File: rtl/ama_riscv_fetch.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | ama_riscv_fetch: IF stage - PC register, IMEM fetch, bubble insertion   |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module ama_riscv_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0200,
  parameter int unsigned IMEM_AW      = 14,
  parameter logic [31:0] NOP_INST     = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         pc_sel,
  input  logic               pc_we,
  input  logic               stall_if,
  input  logic               clear_if,
  input  logic               clear_id,
  input  logic [31:0]        alu_out,
  input  logic [31:0]        imem_rdata,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        inst_id,
  output logic [31:0]        pc_id,
  output logic [31:0]        pc_inc4_id,
  output logic               fetch_valid
);

  localparam logic [1:0] c_PC_SEL_INC4  = 2'b00;
  localparam logic [1:0] c_PC_SEL_ALU   = 2'b01;
  localparam logic [1:0] c_PC_SEL_START = 2'b10;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pc_id;
  logic [1:0]  r_rst_sync;

  logic [31:0] w_next_pc;
  logic [31:0] w_fetch_pc;
  logic        w_boot;
  logic        w_restart;
  logic        w_pc_we;
  logic        w_bubble;

  always_comb begin
    w_next_pc = r_pc;
    case (pc_sel)
      c_PC_SEL_INC4:  w_next_pc = r_pc + 32'd4;
      c_PC_SEL_ALU:   w_next_pc = alu_out & 32'hFFFF_FFFE;
      c_PC_SEL_START: w_next_pc = RESET_VECTOR;
      default:        w_next_pc = r_pc;
    endcase
  end

  // BOOT keeps re-fetching the current pc so the first RUN cycle sees its word.
  assign w_boot     = (r_state == S_BOOT);
  assign w_restart  = (r_state == S_RUN) && (pc_sel == c_PC_SEL_START);
  assign w_pc_we    = (pc_we || w_restart) && !w_boot;
  assign w_fetch_pc = w_pc_we ? w_next_pc : r_pc;

  assign imem_en    = w_pc_we || w_boot;
  assign imem_addr  = w_fetch_pc[IMEM_AW+1:2];

  assign w_bubble    = clear_if || clear_id || (r_state != S_RUN);
  assign inst_id     = w_bubble ? NOP_INST : imem_rdata;
  assign fetch_valid = !w_bubble;
  assign pc_id       = r_pc_id;
  assign pc_inc4_id  = r_pc_id + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_VECTOR;
      r_pc_id <= RESET_VECTOR;
      r_state <= S_BOOT;
    end else begin
      if (w_pc_we) begin
        r_pc <= w_next_pc;
      end
      if (imem_en) begin
        r_pc_id <= w_fetch_pc;
      end
      case (r_state)
        S_BOOT: begin
          if (r_rst_sync[1]) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_restart) begin
            r_state <= S_BOOT;
          end else if (stall_if) begin
            r_state <= S_STALL;
          end
        end
        S_STALL: begin
          if (!stall_if) begin
            r_state <= S_RUN;
          end
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ama_riscv_fetch.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_ama_riscv_fetch: directed and randomized checks of the IF stage      |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_ama_riscv_fetch;

  localparam int          AW  = 14;
  localparam logic [31:0] RV  = 32'h0000_0200;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    pc_sel = 2'b00;
  logic          pc_we = 1'b0;
  logic          stall_if = 1'b0;
  logic          clear_if = 1'b0;
  logic          clear_id = 1'b0;
  logic [31:0]   alu_out = 32'h0;
  logic [31:0]   imem_rdata = 32'h0;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [31:0]   inst_id;
  logic [31:0]   pc_id;
  logic [31:0]   pc_inc4_id;
  logic          fetch_valid;

  int n_checks = 0;
  int n_pass   = 0;

  ama_riscv_fetch #(
    .RESET_VECTOR(RV),
    .IMEM_AW     (AW),
    .NOP_INST    (NOP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_sel     (pc_sel),
    .pc_we      (pc_we),
    .stall_if   (stall_if),
    .clear_if   (clear_if),
    .clear_id   (clear_id),
    .alu_out    (alu_out),
    .imem_rdata (imem_rdata),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .inst_id    (inst_id),
    .pc_id      (pc_id),
    .pc_inc4_id (pc_inc4_id),
    .fetch_valid(fetch_valid)
  );

  always #5 clk = ~clk;

  // Synchronous-read IMEM whose word k holds 0x1000_0000 + k
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= 32'h1000_0000 + 32'(imem_addr);
  end

  task automatic set_in(input logic [1:0] sel, input logic we, input logic st,
                        input logic cif, input logic cid, input logic [31:0] alu);
    pc_sel = sel; pc_we = we; stall_if = st; clear_if = cif; clear_id = cid; alu_out = alu;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    n_checks++; if (pc_id !== RV) $display("FAIL reset_pc_id: got %h want %h", pc_id, RV); else n_pass++;
    n_checks++; if (inst_id !== NOP) $display("FAIL reset_inst: got %h want %h", inst_id, NOP); else n_pass++;
    n_checks++; if (fetch_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", fetch_valid); else n_pass++;
    n_checks++; if (imem_en !== 1'b1) $display("FAIL reset_imem_en: got %b want 1", imem_en); else n_pass++;
    n_checks++; if (imem_addr !== 14'h080) $display("FAIL reset_imem_addr: got %h want 080", imem_addr); else n_pass++;
    n_checks++; if (pc_inc4_id !== 32'h204) $display("FAIL reset_pc_inc4: got %h want 204", pc_inc4_id); else n_pass++;
  endtask

  task automatic test_boot();
    int k;
    rst_n = 1'b1;
    #1;
    n_checks++; if (fetch_valid !== 1'b0 || inst_id !== NOP)
      $display("FAIL boot_bubble: got valid=%b inst=%h want valid=0 inst=%h", fetch_valid, inst_id, NOP); else n_pass++;
    k = 0;
    while (fetch_valid !== 1'b1 && k < 8) begin
      @(posedge clk); #2; k++;
    end
    n_checks++; if (k != 3) $display("FAIL boot_latency: got %0d cycles want 3", k); else n_pass++;
    n_checks++; if (inst_id !== 32'h1000_0080) $display("FAIL boot_first_inst: got %h want 10000080", inst_id); else n_pass++;
    n_checks++; if (pc_id !== 32'h200) $display("FAIL boot_first_pc: got %h want 200", pc_id); else n_pass++;
    @(posedge clk); #2;
    n_checks++; if (inst_id !== 32'h1000_0081) $display("FAIL boot_second_inst: got %h want 10000081", inst_id); else n_pass++;
    n_checks++; if (pc_id !== 32'h204) $display("FAIL boot_second_pc: got %h want 204", pc_id); else n_pass++;
    n_checks++; if (pc_inc4_id !== 32'h208) $display("FAIL boot_pc_inc4: got %h want 208", pc_inc4_id); else n_pass++;
  endtask

  task automatic test_branch();
    @(posedge clk); #1;
    set_in(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0); #1;
    n_checks++; if (inst_id !== 32'h1000_0082 || pc_id !== 32'h208)
      $display("FAIL branch_pre: got inst=%h pc=%h want 10000082/208", inst_id, pc_id); else n_pass++;
    @(posedge clk); #1;
    set_in(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 32'h300); #1;
    n_checks++; if (inst_id !== NOP || fetch_valid !== 1'b0)
      $display("FAIL branch_bubble: got inst=%h valid=%b want %h/0", inst_id, fetch_valid, NOP); else n_pass++;
    n_checks++; if (imem_addr !== 14'h0C0) $display("FAIL branch_addr: got %h want 0c0", imem_addr); else n_pass++;
    @(posedge clk); #1;
    set_in(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0); #1;
    n_checks++; if (inst_id !== 32'h1000_00C0 || pc_id !== 32'h300 || fetch_valid !== 1'b1)
      $display("FAIL branch_target: got inst=%h pc=%h valid=%b want 100000c0/300/1", inst_id, pc_id, fetch_valid); else n_pass++;
  endtask

  task automatic test_alu_lsb();
    set_in(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 32'h301); #1;
    n_checks++; if (imem_addr !== 14'h0C0) $display("FAIL alu_lsb_addr: got %h want 0c0", imem_addr); else n_pass++;
    @(posedge clk); #1;
    set_in(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0); #1;
    n_checks++; if (pc_id !== 32'h300 || pc_inc4_id !== 32'h304)
      $display("FAIL alu_lsb_pc: got pc=%h inc4=%h want 300/304", pc_id, pc_inc4_id); else n_pass++;
    n_checks++; if (imem_addr !== 14'h0C1) $display("FAIL alu_lsb_next_addr: got %h want 0c1", imem_addr); else n_pass++;
  endtask

  task automatic test_wrap();
    set_in(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    set_in(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0); #1;
    n_checks++; if (pc_id !== 32'hFFFF_FFFC || inst_id !== 32'h1000_3FFF)
      $display("FAIL wrap_top: got pc=%h inst=%h want fffffffc/10003fff", pc_id, inst_id); else n_pass++;
    n_checks++; if (imem_addr !== 14'h000) $display("FAIL wrap_addr: got %h want 000", imem_addr); else n_pass++;
    n_checks++; if (pc_inc4_id !== 32'h0) $display("FAIL wrap_inc4: got %h want 0", pc_inc4_id); else n_pass++;
    @(posedge clk); #2;
    n_checks++; if (pc_id !== 32'h0 || inst_id !== 32'h1000_0000)
      $display("FAIL wrap_zero: got pc=%h inst=%h want 0/10000000", pc_id, inst_id); else n_pass++;
  endtask

  task automatic test_clear();
    set_in(2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0); #1;
    n_checks++; if (inst_id !== NOP || fetch_valid !== 1'b0 || pc_id !== 32'h0)
      $display("FAIL clear_if: got inst=%h valid=%b pc=%h want %h/0/0", inst_id, fetch_valid, pc_id, NOP); else n_pass++;
    @(posedge clk); #1;
    set_in(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0); #1;
    n_checks++; if (inst_id !== NOP || fetch_valid !== 1'b0 || pc_id !== 32'h4)
      $display("FAIL clear_id: got inst=%h valid=%b pc=%h want %h/0/4", inst_id, fetch_valid, pc_id, NOP); else n_pass++;
    @(posedge clk); #1;
    set_in(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0); #1;
    n_checks++; if (inst_id !== 32'h1000_0002 || fetch_valid !== 1'b1 || pc_id !== 32'h8)
      $display("FAIL clear_after: got inst=%h valid=%b pc=%h want 10000002/1/8", inst_id, fetch_valid, pc_id); else n_pass++;
  endtask

  task automatic test_restart();
    set_in(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0); #1;
    n_checks++; if (imem_addr !== 14'h080) $display("FAIL restart_addr: got %h want 080", imem_addr); else n_pass++;
    @(posedge clk); #1;
    set_in(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0); #1;
    n_checks++; if (fetch_valid !== 1'b0 || imem_addr !== 14'h080)
      $display("FAIL restart_bubble: got valid=%b addr=%h want 0/080", fetch_valid, imem_addr); else n_pass++;
    @(posedge clk); #2;
    n_checks++; if (inst_id !== 32'h1000_0080 || pc_id !== 32'h200 || fetch_valid !== 1'b1)
      $display("FAIL restart_first: got inst=%h pc=%h valid=%b want 10000080/200/1", inst_id, pc_id, fetch_valid); else n_pass++;
  endtask

  task automatic test_async_reset();
    int k;
    repeat (3) @(posedge clk);
    #3;
    n_checks++; if (pc_id !== 32'h20C) $display("FAIL areset_pre: got %h want 20c", pc_id); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (pc_id !== RV || inst_id !== NOP || fetch_valid !== 1'b0)
      $display("FAIL areset_out: got pc=%h inst=%h valid=%b want %h/%h/0", pc_id, inst_id, fetch_valid, RV, NOP); else n_pass++;
    n_checks++; if (imem_addr !== 14'h080 || imem_en !== 1'b1)
      $display("FAIL areset_imem: got addr=%h en=%b want 080/1", imem_addr, imem_en); else n_pass++;
    #2;
    rst_n = 1'b1;
    k = 0;
    while (fetch_valid !== 1'b1 && k < 8) begin
      @(posedge clk); #2; k++;
    end
    n_checks++; if (k >= 8) $display("FAIL areset_timeout: got %0d cycles want <8", k); else n_pass++;
    n_checks++; if (inst_id !== 32'h1000_0080 || pc_id !== 32'h200)
      $display("FAIL areset_first: got inst=%h pc=%h want 10000080/200", inst_id, pc_id); else n_pass++;
  endtask

  // Reference: pc advances only on accepted writes, pc_id names the word last
  // read from IMEM, and the output is a bubble in boot, stall or on any clear.
  task automatic test_random();
    logic [31:0]   m_pc, m_pc_id, nxt, fpc, exp_inst;
    int            m_boot_left;
    bit            m_stall, boot, we, bubble, exp_en;
    logic [AW-1:0] exp_addr;
    int            r;
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_pc = RV; m_pc_id = RV; m_boot_left = 3; m_stall = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      boot = (m_boot_left > 0);
      r = $urandom_range(0, 15);
      alu_out  = ($urandom_range(0, 1) == 1) ? $urandom : {16'h0, 16'($urandom)};
      clear_if = ($urandom_range(0, 9) == 0);
      clear_id = ($urandom_range(0, 14) == 0);
      if (!boot && m_stall) begin
        stall_if = ($urandom_range(0, 2) == 0);
        pc_we    = !stall_if;
        pc_sel   = stall_if ? 2'(($urandom_range(0, 1) == 1) ? 2'b00 : 2'b11) : 2'b01;
      end else begin
        pc_sel   = (r == 0) ? 2'b10 : (r < 4) ? 2'b01 : (r == 4) ? 2'b11 : 2'b00;
        pc_we    = (pc_sel == 2'b10) ? 1'b1 : ($urandom_range(0, 7) != 0);
        stall_if = (pc_sel == 2'b10) ? 1'b0 : ($urandom_range(0, 7) == 0);
      end
      #1;
      case (pc_sel)
        2'b00:   nxt = m_pc + 32'd4;
        2'b01:   nxt = {alu_out[31:1], 1'b0};
        2'b10:   nxt = RV;
        default: nxt = m_pc;
      endcase
      we       = !boot && pc_we;
      fpc      = we ? nxt : m_pc;
      exp_en   = boot || pc_we;
      exp_addr = fpc[AW+1:2];
      bubble   = boot || m_stall || clear_if || clear_id;
      exp_inst = bubble ? NOP : 32'h1000_0000 + 32'(m_pc_id[AW+1:2]);
      n_checks++; if (inst_id !== exp_inst) $display("FAIL rnd_inst c%0d: got %h want %h", cyc, inst_id, exp_inst); else n_pass++;
      n_checks++; if (fetch_valid !== !bubble) $display("FAIL rnd_valid c%0d: got %b want %b", cyc, fetch_valid, !bubble); else n_pass++;
      n_checks++; if (pc_id !== m_pc_id) $display("FAIL rnd_pc_id c%0d: got %h want %h", cyc, pc_id, m_pc_id); else n_pass++;
      n_checks++; if (pc_inc4_id !== m_pc_id + 32'd4) $display("FAIL rnd_inc4 c%0d: got %h want %h", cyc, pc_inc4_id, m_pc_id + 32'd4); else n_pass++;
      n_checks++; if (imem_en !== exp_en) $display("FAIL rnd_en c%0d: got %b want %b", cyc, imem_en, exp_en); else n_pass++;
      n_checks++; if (imem_addr !== exp_addr) $display("FAIL rnd_addr c%0d: got %h want %h", cyc, imem_addr, exp_addr); else n_pass++;
      if (we) m_pc = nxt;
      if (exp_en) m_pc_id = fpc;
      if (boot) m_boot_left--;
      else if (m_stall) m_stall = stall_if;
      else if (pc_sel == 2'b10) m_boot_left = 1;
      else if (stall_if) m_stall = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_branch();
    test_alu_lsb();
    test_wrap();
    test_clear();
    test_restart();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
